// File: rtl/core_pkg.sv
// Shared core definitions used by the memory-stage controller.
// Holds the access FSM encoding and the default watchdog limit.
package core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        ERR
    } mem_state_t;

    localparam int MEM_TIMEOUT = 255;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Clear/enable cycle counter with a terminal-count flag.
// Shared by the load/store path and the instruction-fetch path.
module mem_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(LIMIT);

    logic [W-1:0] cnt;

    assign tc = (cnt == W'(LIMIT - 1));

    // Count enabled cycles; park at the terminal value until cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Memory-stage access controller: issues M-stage loads/stores,
// stalls the front of the pipe and hands load data to W.
module mem_stall_ctrl
    import core_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = MEM_TIMEOUT,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemReqM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rdata,
    output logic          StallM,
    output logic          EnMW,
    output logic          FlushW,
    output logic [DW-1:0] ReadDataW,
    output logic          MemErr,
    output logic [CW-1:0] StallCount
);

    mem_state_t    state;
    mem_state_t    state_next;

    logic          issue;
    logic          take_rsp;
    logic          abort;
    logic          tc;
    logic          cnt_en;
    logic          cnt_clr;

    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] rdata_buf;

    // Holding reset keeps a pending M access from leaking onto the bus
    assign issue   = (state == IDLE) && MemReqM && !reset;
    assign cnt_en  = (state == REQ) || (state == WAIT);
    assign cnt_clr = (state == IDLE);

    mem_timeout_cnt #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk  (clk),
        .reset(reset),
        .clear(cnt_clr),
        .en   (cnt_en),
        .tc   (tc)
    );

    // Access state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, request channel and pipeline control
    always_comb begin
        state_next    = state;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        StallM        = 1'b0;
        EnMW          = 1'b1;
        FlushW        = 1'b0;
        take_rsp      = 1'b0;
        abort         = 1'b0;
        unique case (state)
            IDLE: begin
                if (issue) begin
                    mem_req_valid = 1'b1;
                    mem_we        = MemWriteM;
                    mem_addr      = ALUResultM;
                    mem_wdata     = WriteDataM;
                    StallM        = 1'b1;
                    EnMW          = 1'b0;
                    FlushW        = 1'b1;
                    state_next    = mem_req_ready ? WAIT : REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_we        = req_we;
                mem_addr      = req_addr;
                mem_wdata     = req_wdata;
                StallM        = 1'b1;
                EnMW          = 1'b0;
                FlushW        = 1'b1;
                if (tc) begin
                    abort      = 1'b1;
                    state_next = ERR;
                end else if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                StallM = 1'b1;
                EnMW   = 1'b0;
                FlushW = 1'b1;
                if (mem_rsp_valid) begin
                    take_rsp   = 1'b1;
                    state_next = DONE;
                end else if (tc) begin
                    abort      = 1'b1;
                    state_next = ERR;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Snapshot the request so the payload stays put under backpressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (issue) begin
            req_we    <= MemWriteM;
            req_addr  <= ALUResultM;
            req_wdata <= WriteDataM;
        end
    end

    // Response buffer: load data on ack, zero on abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_buf <= '0;
        end else if (abort) begin
            rdata_buf <= '0;
        end else if (take_rsp && !req_we) begin
            rdata_buf <= mem_rdata;
        end
    end

    // W-stage load data advances with the M/W register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ReadDataW <= '0;
        end else if (EnMW) begin
            ReadDataW <= rdata_buf;
        end
    end

    // Sticky watchdog error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MemErr <= 1'b0;
        end else if (abort) begin
            MemErr <= 1'b1;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCount <= '0;
        end else if (StallM && !(&StallCount)) begin
            StallCount <= StallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl with a randomized memory
// and a per-access latency/timeout reference model.
module tb_mem_stall_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          MemReqM = 1'b0;
    logic          MemWriteM = 1'b0;
    logic [AW-1:0] ALUResultM = '0;
    logic [DW-1:0] WriteDataM = '0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rsp_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          StallM;
    logic          EnMW;
    logic          FlushW;
    logic [DW-1:0] ReadDataW;
    logic          MemErr;
    logic [CW-1:0] StallCount;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] m_rd = '0;
    logic [CW-1:0] m_sc = '0;
    logic          m_err = 1'b0;

    mem_stall_ctrl #(
        .AW(AW), .DW(DW), .TIMEOUT(T), .CW(CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemReqM      (MemReqM),
        .MemWriteM    (MemWriteM),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata    (mem_rdata),
        .StallM       (StallM),
        .EnMW         (EnMW),
        .FlushW       (FlushW),
        .ReadDataW    (ReadDataW),
        .MemErr       (MemErr),
        .StallCount   (StallCount)
    );

    always #5 clk = ~clk;

    // One access: ready comes r cycles after issue, response lat cycles
    // after acceptance. It completes iff r+lat <= T, else it aborts
    // after T REQ/WAIT cycles. Stalled cycles = min(r+lat,T)+1.
    task automatic run_access(input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata,
                              input logic [DW-1:0] rdata,
                              input int r, input int lat);
        int e;
        logic tout;
        logic [DW-1:0] rd0;
        logic err0;
        tout = (r + lat > T);
        e    = tout ? T : r + lat;
        rd0  = m_rd;
        err0 = m_err;
        MemReqM = 1'b1;
        for (int k = 0; k <= e + 1; k++) begin
            if (k == 0) begin
                MemWriteM  = we;
                ALUResultM = addr;
                WriteDataM = wdata;
            end else begin
                MemWriteM  = 1'($urandom);
                ALUResultM = $urandom;
                WriteDataM = $urandom;
            end
            mem_req_ready = (k >= r);
            mem_rsp_valid = (k == r + lat);
            mem_rdata     = (k == r + lat) ? rdata : $urandom;
            #1;
            total++;
            if (mem_req_valid !== (k <= r && k <= e)) begin
                bad++;
                $display("FAIL req_valid k=%0d got=%b exp=%b",
                         k, mem_req_valid, (k <= r && k <= e));
            end
            total++;
            if (StallM !== (k <= e)) begin
                bad++;
                $display("FAIL stall k=%0d got=%b exp=%b",
                         k, StallM, (k <= e));
            end
            total++;
            if (EnMW !== (k > e) || FlushW !== (k <= e)) begin
                bad++;
                $display("FAIL en_flush k=%0d got=%b%b exp=%b%b",
                         k, EnMW, FlushW, (k > e), (k <= e));
            end
            total++;
            if (ReadDataW !== rd0) begin
                bad++;
                $display("FAIL rdw_hold k=%0d got=%h exp=%h",
                         k, ReadDataW, rd0);
            end
            total++;
            if (MemErr !== (err0 | (tout && k == e + 1))) begin
                bad++;
                $display("FAIL memerr k=%0d got=%b exp=%b",
                         k, MemErr, (err0 | (tout && k == e + 1)));
            end
            if (k <= r && k <= e) begin
                total++;
                if (mem_addr !== addr || mem_wdata !== wdata
                    || mem_we !== we) begin
                    bad++;
                    $display("FAIL payload k=%0d got=%h/%h/%b exp=%h/%h/%b",
                             k, mem_addr, mem_wdata, mem_we,
                             addr, wdata, we);
                end
            end
            @(posedge clk);
            #1;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        if (tout) m_rd = '0;
        else if (!we) m_rd = rdata;
        m_err = m_err | tout;
        m_sc  = m_sc + CW'(e + 1);
        total++;
        if (ReadDataW !== m_rd) begin
            bad++;
            $display("FAIL rdw_after got=%h exp=%h", ReadDataW, m_rd);
        end
        total++;
        if (StallCount !== m_sc) begin
            bad++;
            $display("FAIL stallcount got=%0d exp=%0d", StallCount, m_sc);
        end
        total++;
        if (MemErr !== m_err) begin
            bad++;
            $display("FAIL memerr_after got=%b exp=%b", MemErr, m_err);
        end
    endtask

    // Non-memory cycles, optionally with stray responses that must be ignored
    task automatic idle_cycles(input int n, input bit stray);
        MemReqM = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_rsp_valid = stray ? 1'($urandom) : 1'b0;
            mem_rdata     = $urandom;
            ALUResultM    = $urandom;
            #1;
            total++;
            if (StallM !== 1'b0 || EnMW !== 1'b1 || mem_req_valid !== 1'b0
                || FlushW !== 1'b0) begin
                bad++;
                $display("FAIL idle i=%0d stall=%b en=%b valid=%b flush=%b",
                         i, StallM, EnMW, mem_req_valid, FlushW);
            end
            @(posedge clk);
            #1;
        end
        mem_rsp_valid = 1'b0;
        total++;
        if (ReadDataW !== m_rd) begin
            bad++;
            $display("FAIL idle_rdw got=%h exp=%h", ReadDataW, m_rd);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (mem_req_valid !== 1'b0 || StallM !== 1'b0 || EnMW !== 1'b1
            || FlushW !== 1'b0 || ReadDataW !== '0 || MemErr !== 1'b0
            || StallCount !== '0) begin
            bad++;
            $display("FAIL reset v=%b s=%b en=%b f=%b rd=%h err=%b sc=%0d",
                     mem_req_valid, StallM, EnMW, FlushW, ReadDataW,
                     MemErr, StallCount);
        end
        reset = 1'b0;
        m_rd = '0;
        m_sc = '0;
        m_err = 1'b0;
    endtask

    task automatic test_nonmem();
        idle_cycles(5, 1'b1);
        total++;
        if (StallCount !== '0) begin
            bad++;
            $display("FAIL nonmem_sc got=%0d exp=0", StallCount);
        end
    endtask

    task automatic test_load_zero_wait();
        run_access(1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 0, 1);
        total++;
        if (ReadDataW !== 32'hCAFEF00D || StallCount !== 16'd2) begin
            bad++;
            $display("FAIL load0 got=%h/%0d exp=cafef00d/2",
                     ReadDataW, StallCount);
        end
        idle_cycles(1, 1'b0);
    endtask

    task automatic test_store_backpressure();
        run_access(1'b1, 32'h40, 32'h12345678, 32'hBADBAD00, 3, 2);
        total++;
        if (ReadDataW !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL store_rdw got=%h exp=cafef00d", ReadDataW);
        end
        idle_cycles(1, 1'b0);
    endtask

    task automatic test_timeout();
        total++;
        if (MemErr !== 1'b0) begin
            bad++;
            $display("FAIL pre_timeout err got=%b exp=0", MemErr);
        end
        run_access(1'b0, 32'h200, 32'h0, 32'h11112222, 0, 20);
        total++;
        if (MemErr !== 1'b1 || ReadDataW !== '0) begin
            bad++;
            $display("FAIL timeout got=%b/%h exp=1/0", MemErr, ReadDataW);
        end
        run_access(1'b0, 32'h204, 32'h0, 32'h33334444, 1, 2);
        total++;
        if (MemErr !== 1'b1) begin
            bad++;
            $display("FAIL sticky got=%b exp=1", MemErr);
        end
        idle_cycles(1, 1'b0);
    endtask

    task automatic test_reset_in_wait();
        MemReqM       = 1'b1;
        MemWriteM     = 1'b0;
        ALUResultM    = 32'h300;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (mem_req_valid !== 1'b0 || StallM !== 1'b0 || EnMW !== 1'b1
            || FlushW !== 1'b0 || ReadDataW !== '0 || MemErr !== 1'b0
            || StallCount !== '0) begin
            bad++;
            $display("FAIL rst_wait v=%b s=%b en=%b f=%b rd=%h err=%b sc=%0d",
                     mem_req_valid, StallM, EnMW, FlushW, ReadDataW,
                     MemErr, StallCount);
        end
        @(posedge clk);
        #1;
        reset         = 1'b0;
        MemReqM       = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hDEADBEEF;
        m_rd = '0;
        m_sc = '0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        idle_cycles(2, 1'b0);
        total++;
        if (ReadDataW !== '0 || StallCount !== '0) begin
            bad++;
            $display("FAIL rst_stray got=%h/%0d exp=0/0",
                     ReadDataW, StallCount);
        end
        run_access(1'b0, 32'h304, 32'h0, 32'h0BADF00D, 0, 1);
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] sc0;
        sc0 = StallCount;
        run_access(1'b0, 32'h400, 32'h0, 32'hA5A5A5A5, 0, 1);
        run_access(1'b0, 32'h404, 32'h0, 32'h5A5A5A5A, 0, 1);
        total++;
        if (StallCount !== sc0 + 16'd4 || ReadDataW !== 32'h5A5A5A5A) begin
            bad++;
            $display("FAIL b2b got=%0d/%h exp=%0d/5a5a5a5a",
                     StallCount, ReadDataW, sc0 + 16'd4);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int r;
            int lat;
            r   = ($urandom % 4 == 0) ? $urandom_range(0, 9)
                                      : $urandom_range(0, 3);
            lat = $urandom_range(1, 6);
            run_access(1'($urandom), $urandom, $urandom, $urandom, r, lat);
            if ($urandom % 2 == 1) idle_cycles($urandom_range(1, 2), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_zero_wait();
        test_store_backpressure();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
